// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer issuing fixed-latency instruction reads into a 2-entry {pc, inst} FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);
  logic [31:0]      pc_q, ipc_q;
  logic [1:0]       cnt_q, cnt_d, widx;
  logic             infl_q, pop;
  logic [2:0]       occ;
  logic [1:0][63:0] ent_q, ent_d;
  assign pop        = inst_valid & inst_ready;
  // Slots promised to the FIFO once this cycle's pop and the in-flight response settle
  assign occ        = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign imem_req   = rst_n & ~redirect & (occ < 3'd2);
  assign imem_addr  = pc_q;
  assign inst_valid = rst_n & (cnt_q != 2'd0);
  assign inst_out   = inst_valid ? ent_q[0][31:0] : 32'h0000_0013;
  assign pc_out     = inst_valid ? ent_q[0][63:32] : 32'h0;
  assign opcode     = inst_out[6:0];
  assign funct3     = inst_out[14:12];
  assign funct7     = inst_out[31:25];
  always_comb begin
    widx     = cnt_q - {1'b0, pop};
    ent_d[0] = pop ? ent_q[1] : ent_q[0];
    ent_d[1] = ent_q[1];
    if (infl_q && widx == 2'd0) ent_d[0] = {ipc_q, imem_rdata};
    if (infl_q && widx == 2'd1) ent_d[1] = {ipc_q, imem_rdata};
    cnt_d    = widx + {1'b0, infl_q};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      cnt_q  <= 2'd0;
      infl_q <= 1'b0;
    end else begin
      infl_q <= imem_req;
      pc_q   <= redirect ? {redirect_pc[31:2], 2'b00} : imem_req ? pc_q + 32'd4 : pc_q;
      cnt_q  <= redirect ? 2'd0 : cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (imem_req) ipc_q <= pc_q;
  end
endmodule
